// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and the
// receiver/transmitter state encoding.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bus: byte holding register with valid/ready
// handshake, plus status flags.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;

  modport master (output data_out, valid, busy, frame_err, overrun, input ready);
  modport slave  (input data_out, valid, busy, frame_err, overrun, output ready);

endinterface

// File: rtl/uart_rx_sync_bit.sv
// N-flop synchroniser for a single asynchronous input; resets to 1 so an
// idle-high line does not look like activity coming out of reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling FSM feeding a valid/ready holding
// register with framing-error and overrun reporting.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | counting to the middle of the start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; 1 delivers the byte, 0 flags a framing error
// BREAK | line held low after a bad stop bit; wait for it to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 deliver, ferr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    deliver = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (idx_q == LAST) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte finishing while the previous one is still unaccepted is dropped;
  // the held byte is never overwritten behind the consumer's back.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr;
      ovr_q  <= 1'b0;
      if (valid_q && bus.ready) valid_q <= 1'b0;
      if (deliver) begin
        if (!valid_q || bus.ready) begin
          data_q  <= shreg_d;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
